// File: rtl/transfer_function_pkg.sv
// Shared constants and types for the lock-in transfer-function demodulator:
// command addresses on page 0x42, FSM state encoding and default widths.
package transfer_function_pkg;

   localparam int W_IN_DEF  = 16;
   localparam int W_ACC_DEF = 64;

   localparam logic [15:0] ADDR_LEN    = 16'h4200;
   localparam logic [15:0] ADDR_SETTLE = 16'h4201;
   localparam logic [15:0] ADDR_START  = 16'h4202;
   localparam logic [15:0] ADDR_ABORT  = 16'h4203;

   // Post-integration flush length: covers the product and accumulate stages.
   localparam logic [31:0] DRAIN_CYCLES = 32'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_INTEGRATE,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/lockin_mac.sv
// One lock-in channel: input register, registered full-precision product,
// then a clearable accumulator. A sample-enable bit travels alongside the data
// so a clear (start/abort) flushes anything still in flight.
module lockin_mac #(
   parameter int W_IN  = 16,
   parameter int W_ACC = 64
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [W_IN-1:0]  sig_i,
   input  logic signed [W_IN-1:0]  ref_i,
   output logic signed [W_ACC-1:0] acc_o
);

   localparam int W_PROD = 2 * W_IN;

   logic signed [W_IN-1:0]   sig_q, ref_q;
   logic signed [W_PROD-1:0] sig_x, ref_x, prod_d, prod_q;
   logic signed [W_ACC-1:0]  prod_ext, acc_q;
   logic                     en1_q, en2_q;

   // Widen operands before multiplying so the product is exact at 2*W_IN bits.
   always_comb begin
      sig_x    = {{W_IN{sig_q[W_IN-1]}}, sig_q};
      ref_x    = {{W_IN{ref_q[W_IN-1]}}, ref_q};
      prod_d   = sig_x * ref_x;
      prod_ext = {{(W_ACC-W_PROD){prod_q[W_PROD-1]}}, prod_q};
   end

   // Three-stage pipeline: capture inputs, multiply, accumulate.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sig_q  <= '0;
         ref_q  <= '0;
         en1_q  <= 1'b0;
         prod_q <= '0;
         en2_q  <= 1'b0;
         acc_q  <= '0;
      end else begin
         sig_q  <= sig_i;
         ref_q  <= ref_i;
         en1_q  <= en_i & ~clr_i;
         prod_q <= prod_d;
         en2_q  <= en1_q & ~clr_i;
         if (clr_i) begin
            acc_q <= '0;
         end else if (en2_q) begin
            acc_q <= acc_q + prod_ext;
         end
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/transfer_function_demod.sv
// Lock-in receiver: multiplies the response by cos (I) and sin (Q) references,
// integrates over N samples after S settle cycles, and presents the sums with
// a one-cycle done strobe. Configured over the shared command bus, page 0x42.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | no run active, outputs hold the last completed result
//   ST_SETTLE    | waiting S cycles before sampling
//   ST_INTEGRATE | N sample-enabled cycles fed into the MAC pipelines
//   ST_DRAIN     | 2 cycles for the last products to reach the accumulators
//   ST_DONE      | 1 cycle; leaving it loads i_out/q_out and pulses done_out
module transfer_function_demod
   import transfer_function_pkg::*;
#(
   parameter int W_IN  = W_IN_DEF,
   parameter int W_ACC = W_ACC_DEF
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    cmd_trig_in,
   input  logic [15:0]             cmd_addr_in,
   input  logic [15:0]             cmd_data1_in,
   input  logic [15:0]             cmd_data2_in,
   input  logic signed [W_IN-1:0]  sig_in,
   input  logic signed [W_IN-1:0]  sin_in,
   input  logic signed [W_IN-1:0]  cos_in,
   output logic signed [W_ACC-1:0] i_out,
   output logic signed [W_ACC-1:0] q_out,
   output logic                    done_out,
   output logic                    busy_out
);

   logic [31:0] cmd_word;
   logic        wr_len, wr_settle, do_start, do_abort;

   logic [31:0] len_f_q, settle_f_q, len_eff;
   logic [31:0] len_w_q, len_w_d;
   logic [31:0] cnt_q, cnt_d;
   state_e      state_q, state_d;
   logic        done_d, done_q;
   logic        integ_en, clr;

   logic signed [W_ACC-1:0] i_acc, q_acc, i_q, q_q;

   // Command decode; only the four page-0x42 addresses do anything.
   always_comb begin
      cmd_word  = {cmd_data2_in, cmd_data1_in};
      wr_len    = cmd_trig_in && (cmd_addr_in == ADDR_LEN);
      wr_settle = cmd_trig_in && (cmd_addr_in == ADDR_SETTLE);
      do_start  = cmd_trig_in && (cmd_addr_in == ADDR_START);
      do_abort  = cmd_trig_in && (cmd_addr_in == ADDR_ABORT);
      len_eff   = (len_f_q == 32'd0) ? 32'd1 : len_f_q;
   end

   // Configuration registers; a run works from its own copies taken at start.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         len_f_q    <= 32'd1;
         settle_f_q <= 32'd0;
      end else begin
         if (wr_len)    len_f_q    <= cmd_word;
         if (wr_settle) settle_f_q <= cmd_word;
      end
   end

   // Next-state logic; start and abort override whatever the run is doing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_w_d = len_w_q;
      done_d  = 1'b0;
      if (do_start) begin
         len_w_d = len_eff;
         if (settle_f_q == 32'd0) begin
            state_d = ST_INTEGRATE;
            cnt_d   = len_eff;
         end else begin
            state_d = ST_SETTLE;
            cnt_d   = settle_f_q;
         end
      end else if (do_abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == 32'd1) begin
                  state_d = ST_INTEGRATE;
                  cnt_d   = len_w_q;
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            ST_INTEGRATE: begin
               if (cnt_q == 32'd1) begin
                  state_d = ST_DRAIN;
                  cnt_d   = DRAIN_CYCLES;
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            ST_DRAIN: begin
               if (cnt_q == 32'd1) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM state, down-counter and working length.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= 32'd0;
         len_w_q <= 32'd1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_w_q <= len_w_d;
      end
   end

   // Flushing on abort as well as start keeps stale products out of any run.
   always_comb begin
      integ_en = (state_q == ST_INTEGRATE);
      clr      = do_start | do_abort;
   end

   lockin_mac #(.W_IN(W_IN), .W_ACC(W_ACC)) u_mac_i (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr_i  (clr),
      .en_i   (integ_en),
      .sig_i  (sig_in),
      .ref_i  (cos_in),
      .acc_o  (i_acc)
   );

   lockin_mac #(.W_IN(W_IN), .W_ACC(W_ACC)) u_mac_q (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr_i  (clr),
      .en_i   (integ_en),
      .sig_i  (sig_in),
      .ref_i  (sin_in),
      .acc_o  (q_acc)
   );

   // Result registers and done strobe, loaded on the edge leaving ST_DONE.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         i_q    <= '0;
         q_q    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
         if (done_d) begin
            i_q <= i_acc;
            q_q <= q_acc;
         end
      end
   end

   assign i_out    = i_q;
   assign q_out    = q_q;
   assign done_out = done_q;
   assign busy_out = (state_q != ST_IDLE);

endmodule

// File: tb/tb_transfer_function_demod.sv
// Bench for transfer_function_demod: table of runs with constant expected
// sums and latency, a done-driven scoreboard, and hand sequences for restart,
// abort, ignored addresses, asynchronous reset and zero length.
module tb_transfer_function_demod;
   import transfer_function_pkg::*;

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic               cmd_trig_in;
   logic [15:0]        cmd_addr_in, cmd_data1_in, cmd_data2_in;
   logic signed [15:0] sig_in, sin_in, cos_in;
   logic signed [63:0] i_out, q_out;
   logic               done_out, busy_out;

   transfer_function_demod dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .cmd_trig_in  (cmd_trig_in),
      .cmd_addr_in  (cmd_addr_in),
      .cmd_data1_in (cmd_data1_in),
      .cmd_data2_in (cmd_data2_in),
      .sig_in       (sig_in),
      .sin_in       (sin_in),
      .cos_in       (cos_in),
      .i_out        (i_out),
      .q_out        (q_out),
      .done_out     (done_out),
      .busy_out     (busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int     s;
      int     n;
      int     sig0;
      int     step;
      int     cosv;
      int     sinv;
      longint exp_i;
      longint exp_q;
   } vec_t;

   typedef struct {
      longint i;
      longint q;
      int     t;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;
   exp_t sb[$];
   vec_t vecs[5];

   always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding run.
   always @(negedge clk_in) begin : monitor
      exp_t e;
      if (done_out === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("i_out", i_out, e.i);
            check("q_out", q_out, e.q);
            check("done_time", edge_cnt, e.t);
         end
      end
   end

   task automatic cmd(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk_in);
      cmd_trig_in  = 1'b1;
      cmd_addr_in  = a;
      cmd_data1_in = d[15:0];
      cmd_data2_in = d[31:16];
      @(negedge clk_in);
      cmd_trig_in  = 1'b0;
   endtask

   task automatic drive(input int sig0, input int step, input int cv, input int sv, input int k);
      sig_in = 16'(sig0 + step * k);
      cos_in = 16'(cv);
      sin_in = 16'(sv);
   endtask

   // Value driven at the k-th negedge after the start strobe is present at edge t0+k.
   task automatic run_vec(input vec_t v);
      int t0;
      int nn;
      cmd(ADDR_LEN, v.n);
      cmd(ADDR_SETTLE, v.s);
      @(negedge clk_in);
      cmd_trig_in = 1'b1;
      cmd_addr_in = ADDR_START;
      drive(v.sig0, v.step, v.cosv, v.sinv, 0);
      t0 = edge_cnt + 1;
      nn = (v.n == 0) ? 1 : v.n;
      sb.push_back('{v.exp_i, v.exp_q, t0 + v.s + nn + 3});
      for (int k = 1; k <= v.s + nn + 8; k++) begin
         @(negedge clk_in);
         cmd_trig_in = 1'b0;
         drive(v.sig0, v.step, v.cosv, v.sinv, k);
         if (k == 1)            check("busy_after_start", busy_out, 1);
         if (k == v.s + nn + 3) check("busy_before_done", busy_out, 1);
         if (k == v.s + nn + 4) check("busy_at_done", busy_out, 0);
      end
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stim
      int t0;
      vecs[0] = '{0, 10, 1000, 0, 1000, 1000, 64'sd10000000, 64'sd10000000};
      vecs[1] = '{0, 4, -32768, 0, -32768, 32767, 64'sd4294967296, -64'sd4294836224};
      vecs[2] = '{5, 3, 0, 1, 1, -2, 64'sd21, -64'sd42};
      vecs[3] = '{2, 1, 100, 3, 7, 5, 64'sd763, 64'sd545};
      vecs[4] = '{1, 20, -5, 1, -3, 11, -64'sd390, 64'sd1430};

      rst_in       = 1'b1;
      cmd_trig_in  = 1'b0;
      cmd_addr_in  = '0;
      cmd_data1_in = '0;
      cmd_data2_in = '0;
      sig_in = '0; sin_in = '0; cos_in = '0;
      repeat (3) @(negedge clk_in);
      check("rst_i_out", i_out, 0);
      check("rst_q_out", q_out, 0);
      check("rst_done", done_out, 0);
      check("rst_busy", busy_out, 0);
      rst_in = 1'b0;

      for (int v = 0; v < 5; v++) run_vec(vecs[v]);

      // Addresses off the four command slots must not start a run.
      cmd(16'h4302, 32'd0);
      check("ignored_page", busy_out, 0);
      cmd(16'h4204, 32'd0);
      check("ignored_slot", busy_out, 0);

      // Restart mid-INTEGRATE: only the second run reports, with its own samples.
      cmd(ADDR_LEN, 8);
      cmd(ADDR_SETTLE, 0);
      @(negedge clk_in);
      cmd_trig_in = 1'b1;
      cmd_addr_in = ADDR_START;
      drive(999, 0, 2, 3, 0);
      repeat (4) begin
         @(negedge clk_in);
         cmd_trig_in = 1'b0;
      end
      cmd_trig_in = 1'b1;
      cmd_addr_in = ADDR_START;
      drive(0, 1, 2, 3, 0);
      t0 = edge_cnt + 1;
      sb.push_back('{64'sd72, 64'sd108, t0 + 11});
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk_in);
         cmd_trig_in = 1'b0;
         drive(0, 1, 2, 3, k);
      end
      if (sb.size() != 0) begin
         check("restart_done_timeout", sb.size(), 0);
         sb.delete();
      end

      // Abort during DRAIN: no done, outputs keep the restart run's result.
      cmd(ADDR_LEN, 3);
      @(negedge clk_in);
      cmd_trig_in = 1'b1;
      cmd_addr_in = ADDR_START;
      drive(50, 0, 4, 4, 0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_in);
         cmd_trig_in = (k == 4);
         cmd_addr_in = ADDR_ABORT;
         if (k == 5) check("abort_busy", busy_out, 0);
      end
      check("abort_i_hold", i_out, 64'sd72);
      check("abort_q_hold", q_out, 64'sd108);

      // Asynchronous reset mid-SETTLE clears outputs before the next edge.
      cmd(ADDR_LEN, 2);
      cmd(ADDR_SETTLE, 10);
      @(negedge clk_in);
      cmd_trig_in = 1'b1;
      cmd_addr_in = ADDR_START;
      repeat (3) begin
         @(negedge clk_in);
         cmd_trig_in = 1'b0;
      end
      #2 rst_in = 1'b1;
      #1;
      check("arst_i_out", i_out, 0);
      check("arst_q_out", q_out, 0);
      check("arst_busy", busy_out, 0);
      check("arst_done", done_out, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (15) @(negedge clk_in);
      check("arst_stays_idle", busy_out, 0);

      // Zero length integrates exactly one sample.
      run_vec('{0, 0, 100, 3, 7, 5, 64'sd721, 64'sd515});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
